// File: rtl/encoder.sv
// 8-to-3 registered priority encoder with a valid flag (bit 7 has the highest priority).
// Define ENCODER_ERR_EN to add the registered multi-hot error output 'err'.
module encoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] d,
    output logic [2:0] out,
    output logic       valid
`ifdef ENCODER_ERR_EN
    ,
    output logic       err
`endif
);

    logic [2:0] out_q,   out_d;
    logic       valid_q, valid_d;

    // NOTE: every next-state signal gets a default first, so no path through
    // this block can leave one unassigned and infer a latch.
    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (en) begin
            out_d   = 3'd0;
            valid_d = |d;
            // Ascending scan: the highest set bit is written last and wins.
            for (int i = 0; i < 8; i++) begin
                if (d[i]) begin
                    out_d = 3'(i);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so that every
    // register samples its next-state value from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

`ifdef ENCODER_ERR_EN
    logic err_q, err_d;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    always_comb begin
        err_d = err_q;
        if (en) begin
            err_d = |(d & (d - 8'd1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_encoder.sv
// Scoreboard bench for encoder: the driver queues the expected outputs and a monitor compares them after every edge.
// A reference model computes each result; reset behaviour is checked directly.
module tb_encoder;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [7:0] d     = 8'h00;
    logic [2:0] out;
    logic       valid;
`ifdef ENCODER_ERR_EN
    logic       err;
`endif

    encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (d),
        .out   (out),
        .valid (valid)
`ifdef ENCODER_ERR_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] out;
        logic       valid;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t model_q = '{out: 3'd0, valid: 1'b0, err: 1'b0};
    int   errors  = 0;
    int   checks  = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".out"},   {5'd0, out},   {5'd0, e.out});
        check({tag, ".valid"}, {7'd0, valid}, {7'd0, e.valid});
`ifdef ENCODER_ERR_EN
        check({tag, ".err"},   {7'd0, err},   {7'd0, e.err});
`endif
    endtask

    // Reference: index of the highest set bit, found by counting down from bit 7.
    function automatic exp_t ref_encode(input logic [7:0] v);
        exp_t r;
        r.out   = 3'd0;
        r.valid = (v != 8'h00);
        r.err   = ($countones(v) >= 2);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r.out = 3'(i);
                break;
            end
        end
        return r;
    endfunction

    // Inputs change on the falling edge; the next rising edge samples them.
    task automatic drive(input logic e, input logic [7:0] v);
        @(negedge clk);
        en = e;
        d  = v;
        if (e) model_q = ref_encode(v);
        sb.push_back(model_q);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 8'(sb.size()), 8'd0);
    endtask

    task automatic reset_zero(input string tag);
        exp_t z;
        z = '{out: 3'd0, valid: 1'b0, err: 1'b0};
        check_outputs(tag, z);
    endtask

    // Monitor: outputs are presented every cycle, so one queued entry is consumed per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_outputs("mon", e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] onehot [6];
        onehot = '{8'h80, 8'h40, 8'h20, 8'h02, 8'h04, 8'h10};

        // Reset held with the clock running and all-ones input.
        en = 1'b1;
        d  = 8'hFF;
        repeat (4) begin
            @(negedge clk);
            reset_zero("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;

        // One-hot sweep, then zero input, priority with multi-hot, and bit 0.
        foreach (onehot[i]) drive(1'b1, onehot[i]);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'b0010_0110);
        drive(1'b1, 8'h01);

        // Hold: en low keeps the previous result while d changes.
        drive(1'b1, 8'h40);
        repeat (3) drive(1'b0, 8'h02);
        drive(1'b1, 8'hFF);
        drive(1'b0, 8'h00);

        // Randomised traffic with a mix of zero, one-hot and arbitrary vectors.
        for (int k = 0; k < 300; k++) begin
            logic [7:0] v;
            case ($urandom_range(0, 3))
                0:       v = 8'h00;
                1:       v = 8'h01 << $urandom_range(0, 7);
                default: v = 8'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, v);
        end
        wait_drain();

        // Mid-operation reset between edges clears immediately.
        drive(1'b1, 8'h80);
        wait_drain();
        check("pre_reset.out", {5'd0, out}, 8'd7);
        #2;
        rst_n = 1'b0;
        #1;
        reset_zero("async_clr");
        model_q = '{out: 3'd0, valid: 1'b0, err: 1'b0};
        en = 1'b1;
        d  = 8'hFF;
        repeat (2) begin
            @(negedge clk);
            reset_zero("rst_mid_hold");
        end
        rst_n = 1'b1;
        en    = 1'b0;
        drive(1'b1, 8'h08);
        wait_drain();
        check("post_reset.out", {5'd0, out}, 8'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
